// File: rtl/traffic_pkg.sv
// Shared definitions for the intersection light monitor.
// Light encodings, phase codes, dwell defaults and the legal phase order.
package traffic_pkg;

    localparam logic [2:0] LT_RED    = 3'b100;
    localparam logic [2:0] LT_YELLOW = 3'b010;
    localparam logic [2:0] LT_GREEN  = 3'b001;

    localparam logic [3:0] PH_ALL_RED = 4'd0;
    localparam logic [3:0] PH_N_Y     = 4'd1;
    localparam logic [3:0] PH_N_G     = 4'd2;
    localparam logic [3:0] PH_E_Y     = 4'd3;
    localparam logic [3:0] PH_E_G     = 4'd4;
    localparam logic [3:0] PH_S_Y     = 4'd5;
    localparam logic [3:0] PH_S_G     = 4'd6;
    localparam logic [3:0] PH_W_Y     = 4'd7;
    localparam logic [3:0] PH_W_G     = 4'd8;
    localparam logic [3:0] PH_INVALID = 4'd15;

    localparam int DEF_ALLRED_CYC = 10;
    localparam int DEF_YEL_CYC    = 5;
    localparam int DEF_GRN_CYC    = 30;
    localparam int DEF_TOL        = 1;
    localparam int DEF_CNT_W      = 8;

    localparam int ERR_CONFLICT = 0;
    localparam int ERR_ENCODING = 1;
    localparam int ERR_SEQUENCE = 2;
    localparam int ERR_TIMING   = 3;

    typedef enum logic {
        ST_SYNC,
        ST_TRACK
    } mon_state_t;

    // Only successor a phase may hand over to; ALL_RED is never a successor.
    function automatic logic [3:0] next_phase(input logic [3:0] ph);
        logic [3:0] nxt;
        case (ph)
            PH_ALL_RED: nxt = PH_N_Y;
            PH_N_Y:     nxt = PH_N_G;
            PH_N_G:     nxt = PH_E_Y;
            PH_E_Y:     nxt = PH_E_G;
            PH_E_G:     nxt = PH_S_Y;
            PH_S_Y:     nxt = PH_S_G;
            PH_S_G:     nxt = PH_W_Y;
            PH_W_Y:     nxt = PH_W_G;
            PH_W_G:     nxt = PH_N_Y;
            default:    nxt = PH_INVALID;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/tl_phase_decoder.sv
// Combinational decode of the four light buses into one phase code.
// Flags malformed buses and more than one non-red approach.
module tl_phase_decoder
    import traffic_pkg::*;
(
    input  logic [2:0] north_lights,
    input  logic [2:0] east_lights,
    input  logic [2:0] south_lights,
    input  logic [2:0] west_lights,
    output logic [3:0] phase,
    output logic       enc_err,
    output logic       conflict_err
);

    logic [3:0][2:0] bus;
    logic [3:0]      legal;
    logic [3:0]      lit;
    logic [2:0]      n_lit;

    assign bus = {west_lights, south_lights, east_lights, north_lights};

    // Per-bus legality, non-red count and phase of the lit approach.
    always_comb begin
        legal = '0;
        lit   = '0;
        n_lit = '0;
        phase = PH_ALL_RED;
        for (int i = 0; i < 4; i++) begin
            legal[i] = (bus[i] == LT_RED) ||
                       (bus[i] == LT_YELLOW) ||
                       (bus[i] == LT_GREEN);
            lit[i]   = (bus[i] != LT_RED);
            n_lit    = n_lit + 3'(lit[i]);
            if (lit[i]) begin
                phase = 4'(2 * i + 1) + {3'b000, bus[i][0]};
            end
        end
        enc_err      = ~&legal;
        conflict_err = (n_lit > 3'd1);
        if (enc_err || conflict_err) begin
            phase = PH_INVALID;
        end
    end

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive checker beside the intersection controller.
// Tracks phase, dwell, rotations and latches sequence/timing/bus faults.
module traffic_light_monitor
    import traffic_pkg::*;
#(
    parameter int ALLRED_CYC = DEF_ALLRED_CYC,
    parameter int YEL_CYC    = DEF_YEL_CYC,
    parameter int GRN_CYC    = DEF_GRN_CYC,
    parameter int TOL        = DEF_TOL,
    parameter int CNT_W      = DEF_CNT_W
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       north_lights,
    input  logic [2:0]       east_lights,
    input  logic [2:0]       south_lights,
    input  logic [2:0]       west_lights,
    input  logic             clr_err,
    output logic [3:0]       phase,
    output logic [CNT_W-1:0] dwell,
    output logic             locked,
    output logic [15:0]      rotations,
    output logic [3:0]       err_pulse,
    output logic [3:0]       err_status
);

    localparam logic [CNT_W-1:0] DW_MAX = '1;

    logic [2:0] cap_n;
    logic [2:0] cap_e;
    logic [2:0] cap_s;
    logic [2:0] cap_w;
    // Capture regs reset to 000, which is not a legal bus; this marks
    // them as holding real samples so reset itself never looks like a fault.
    logic       cap_vld;

    logic [3:0] dec_phase;
    logic       dec_enc;
    logic       dec_conf;

    mon_state_t state;
    logic       stuck;

    logic             changed;
    logic             new_valid;
    logic             vv_change;
    logic             in_win;
    logic             seq_bad;
    logic             tim_bad;
    logic             stuck_hit;
    logic [CNT_W-1:0] dwell_inc;
    logic [3:0]       pulse_nxt;
    int               exp_c;

    tl_phase_decoder u_dec (
        .north_lights (cap_n),
        .east_lights  (cap_e),
        .south_lights (cap_s),
        .west_lights  (cap_w),
        .phase        (dec_phase),
        .enc_err      (dec_enc),
        .conflict_err (dec_conf)
    );

    function automatic int exp_dwell(input logic [3:0] ph);
        int e;
        unique case (1'b1)
            (ph == PH_ALL_RED): e = ALLRED_CYC;
            ph[0]:              e = YEL_CYC;
            default:            e = GRN_CYC;
        endcase
        return e;
    endfunction

    // Evaluate the captured sample against the previous phase and dwell.
    always_comb begin
        changed   = (dec_phase != phase);
        new_valid = (dec_phase != PH_INVALID);
        vv_change = cap_vld && changed && new_valid &&
                    (phase != PH_INVALID);
        exp_c     = exp_dwell(phase);
        in_win    = (int'(dwell) >= exp_c - TOL) &&
                    (int'(dwell) <= exp_c + TOL);
        dwell_inc = (dwell == DW_MAX) ? dwell : dwell + CNT_W'(1);
        seq_bad   = vv_change && (dec_phase != next_phase(phase));
        tim_bad   = vv_change && (state == ST_TRACK) &&
                    !stuck && !in_win;
        stuck_hit = cap_vld && (state == ST_TRACK) && new_valid &&
                    !changed && !stuck &&
                    (int'(dwell_inc) == exp_c + TOL + 1);
        pulse_nxt               = '0;
        pulse_nxt[ERR_TIMING]   = tim_bad || stuck_hit;
        pulse_nxt[ERR_SEQUENCE] = seq_bad;
        pulse_nxt[ERR_ENCODING] = cap_vld && dec_enc;
        pulse_nxt[ERR_CONFLICT] = cap_vld && dec_conf;
    end

    // Input capture, SYNC/TRACK tracking, dwell, rotations and fault flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cap_n      <= '0;
            cap_e      <= '0;
            cap_s      <= '0;
            cap_w      <= '0;
            cap_vld    <= 1'b0;
            state      <= ST_SYNC;
            stuck      <= 1'b0;
            phase      <= PH_INVALID;
            dwell      <= '0;
            locked     <= 1'b0;
            rotations  <= '0;
            err_pulse  <= '0;
            err_status <= '0;
        end else begin
            cap_n      <= north_lights;
            cap_e      <= east_lights;
            cap_s      <= south_lights;
            cap_w      <= west_lights;
            cap_vld    <= 1'b1;
            err_pulse  <= pulse_nxt;
            err_status <= (clr_err ? 4'b0000 : err_status) | pulse_nxt;
            if (cap_vld) begin
                phase <= dec_phase;
                if (!new_valid) begin
                    state  <= ST_SYNC;
                    locked <= 1'b0;
                    stuck  <= 1'b0;
                    dwell  <= '0;
                end else if (changed) begin
                    stuck <= 1'b0;
                    dwell <= CNT_W'(1);
                    if (vv_change) begin
                        state  <= ST_TRACK;
                        locked <= 1'b1;
                    end
                    if (vv_change && (state == ST_TRACK) &&
                        (phase == PH_W_G) && (dec_phase == PH_N_Y)) begin
                        rotations <= rotations + 16'd1;
                    end
                end else begin
                    dwell <= dwell_inc;
                    if (stuck_hit) begin
                        stuck <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for traffic_light_monitor.
// Outputs are sampled 1 time unit after the rising edge.
module tb_traffic_light_monitor;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] n_l = 3'b100;
    logic [2:0] e_l = 3'b100;
    logic [2:0] s_l = 3'b100;
    logic [2:0] w_l = 3'b100;
    logic       clr_err = 1'b0;
    logic [3:0] phase;
    logic [7:0] dwell;
    logic       locked;
    logic [15:0] rotations;
    logic [3:0] err_pulse;
    logic [3:0] err_status;

    int checks = 0;
    int errors = 0;

    traffic_light_monitor dut (
        .clk          (clk),
        .rst          (rst),
        .north_lights (n_l),
        .east_lights  (e_l),
        .south_lights (s_l),
        .west_lights  (w_l),
        .clr_err      (clr_err),
        .phase        (phase),
        .dwell        (dwell),
        .locked       (locked),
        .rotations    (rotations),
        .err_pulse    (err_pulse),
        .err_status   (err_status)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive the bus pattern of phase ph (0 all red, odd yellow, even green).
    task automatic set_ph(input int ph);
        logic [2:0] col;
        n_l = 3'b100;
        e_l = 3'b100;
        s_l = 3'b100;
        w_l = 3'b100;
        if (ph != 0) begin
            col = (ph % 2 == 1) ? 3'b010 : 3'b001;
            case ((ph - 1) / 2)
                0:       n_l = col;
                1:       e_l = col;
                2:       s_l = col;
                default: w_l = col;
            endcase
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_phase"}, phase, 15);
        chk({tag, "_dwell"}, dwell, 0);
        chk({tag, "_locked"}, locked, 0);
        chk({tag, "_rot"}, rotations, 0);
        chk({tag, "_pulse"}, err_pulse, 0);
        chk({tag, "_status"}, err_status, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        set_ph(0);
        cyc(2);
        chk_reset("rst");
        #2 rst = 1'b1;

        // Full legal rotation
        cyc(10);
        chk("t1_ar_phase", phase, 0);
        chk("t1_ar_dwell", dwell, 9);
        chk("t1_ar_unlocked", locked, 0);
        set_ph(1); cyc(2);
        chk("t1_lock", locked, 1);
        chk("t1_ny_phase", phase, 1);
        chk("t1_ny_dwell", dwell, 1);
        cyc(3);
        set_ph(2); cyc(30); set_ph(3); cyc(5);
        set_ph(4); cyc(30); set_ph(5); cyc(5);
        set_ph(6); cyc(30); set_ph(7); cyc(5);
        set_ph(8); cyc(30);
        set_ph(1); cyc(2);
        chk("t1_rot", rotations, 1);
        chk("t1_phase", phase, 1);
        chk("t1_status", err_status, 0);
        chk("t1_locked", locked, 1);

        // Stuck green
        cyc(3);
        set_ph(2); cyc(30); set_ph(3); cyc(5);
        set_ph(4); cyc(32);
        chk("t2_dwell31", dwell, 31);
        chk("t2_nopulse31", err_pulse, 0);
        set_ph(5); cyc(1);
        chk("t2_dwell32", dwell, 32);
        chk("t2_pulse", err_pulse, 4'b1000);
        chk("t2_status", err_status, 4'b1000);
        cyc(1);
        chk("t2_exit_phase", phase, 5);
        chk("t2_exit_dwell", dwell, 1);
        chk("t2_exit_nopulse", err_pulse, 0);
        chk("t2_exit_status", err_status, 4'b1000);
        chk("t2_exit_locked", locked, 1);
        clr_err = 1'b1; cyc(1); clr_err = 1'b0;
        chk("t2_clr", err_status, 0);

        // Skip from N_G straight to S_Y
        cyc(2);
        set_ph(6); cyc(30); set_ph(7); cyc(5);
        set_ph(8); cyc(30); set_ph(1); cyc(5);
        set_ph(2); cyc(30);
        set_ph(5); cyc(2);
        chk("t3_pulse", err_pulse, 4'b0100);
        chk("t3_phase", phase, 5);
        chk("t3_locked", locked, 1);
        chk("t3_rot", rotations, 2);
        chk("t3_status", err_status, 4'b0100);

        // Two greens at once
        set_ph(0); n_l = 3'b001; e_l = 3'b001; cyc(1);
        set_ph(0); cyc(1);
        chk("t4_pulse", err_pulse, 4'b0001);
        chk("t4_phase", phase, 15);
        chk("t4_locked", locked, 0);
        chk("t4_dwell", dwell, 0);
        chk("t4_status", err_status, 4'b0101);
        cyc(1);
        chk("t4_ar_phase", phase, 0);
        chk("t4_ar_dwell", dwell, 1);
        chk("t4_ar_unlocked", locked, 0);
        cyc(3);
        set_ph(1); cyc(2);
        chk("t4_relock", locked, 1);
        chk("t4_relock_pulse", err_pulse, 0);

        // Malformed west bus with a coincident clear
        set_ph(0); w_l = 3'b011; cyc(1);
        clr_err = 1'b1; set_ph(7); cyc(1); clr_err = 1'b0;
        chk("t5_pulse", err_pulse, 4'b0010);
        chk("t5_status", err_status, 4'b0010);
        chk("t5_phase", phase, 15);
        chk("t5_locked", locked, 0);

        // Asynchronous reset in W_G
        cyc(3);
        set_ph(8); cyc(5);
        chk("t6_wg_phase", phase, 8);
        chk("t6_wg_locked", locked, 1);
        chk("t6_wg_dwell", dwell, 4);
        #3 rst = 1'b0;
        #1;
        chk_reset("t6_async");
        #2 rst = 1'b1;
        cyc(3);
        chk("t6_post_phase", phase, 8);
        chk("t6_post_dwell", dwell, 2);
        chk("t6_post_unlocked", locked, 0);
        set_ph(1); cyc(2);
        chk("t6_first_pulse", err_pulse, 0);
        chk("t6_first_locked", locked, 1);
        chk("t6_first_rot", rotations, 0);
        chk("t6_first_status", err_status, 0);

        // Dwell window edges
        cyc(1);
        set_ph(2); cyc(2);
        chk("t7_short_yellow", err_pulse, 4'b1000);
        cyc(27);
        set_ph(3); cyc(2);
        chk("t7_green_low_edge", err_pulse, 0);
        chk("t7_status", err_status, 4'b1000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
